// File: rtl/cpu_pkg.sv
// Shared constants and types for the single-cycle RV32I core.
// The CPU_MUL_EN macro (used in cpu_core) enables the RV32M MUL instruction.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U: imm = {ins[31:12], 12'b0};
      IMM_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port.
// x0 always reads zero; asynchronous active-low reset clears every register.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core: decode, ALU, branch compare and PC update.
// Define CPU_MUL_EN to add the RV32M MUL instruction; otherwise MUL is a NOP.
module cpu_core
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        im_valid,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_write_data
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rdAddr, rs1Addr, rs2Addr;
  logic [31:0] rs1Data, rs2Data, imm, aluA, aluB, aluResult, wbData, pcPlus4;
  logic        regWrite, srcImm, srcPc, isLoad, isStore, isBranch, isJal, isJalr;
  logic        brTaken, commit;
  alu_op_e     aluOp;
  imm_fmt_e    immFmt;

  assign opcode  = im_data[6:0];
  assign rdAddr  = im_data[11:7];
  assign funct3  = im_data[14:12];
  assign rs1Addr = im_data[19:15];
  assign rs2Addr = im_data[24:20];
  assign funct7  = im_data[31:25];

  // Unrecognised encodings fall through with every control bit low, i.e. a NOP.
  always_comb begin
    regWrite = 1'b0;
    srcImm   = 1'b0;
    srcPc    = 1'b0;
    isLoad   = 1'b0;
    isStore  = 1'b0;
    isBranch = 1'b0;
    isJal    = 1'b0;
    isJalr   = 1'b0;
    aluOp    = ALU_ADD;
    immFmt   = IMM_I;
    case (opcode)
      OPC_LUI:   begin regWrite = 1'b1; srcImm = 1'b1; immFmt = IMM_U; aluOp = ALU_PASSB; end
      OPC_AUIPC: begin regWrite = 1'b1; srcImm = 1'b1; srcPc = 1'b1; immFmt = IMM_U; end
      OPC_JAL:   begin regWrite = 1'b1; isJal = 1'b1; immFmt = IMM_J; end
      OPC_JALR:  if (funct3 == F3_JALR) begin regWrite = 1'b1; isJalr = 1'b1; srcImm = 1'b1; end
      OPC_BRANCH: begin
        immFmt   = IMM_B;
        isBranch = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD:  if (funct3 == F3_WORD) begin regWrite = 1'b1; isLoad = 1'b1; srcImm = 1'b1; end
      OPC_STORE: if (funct3 == F3_WORD) begin isStore = 1'b1; srcImm = 1'b1; immFmt = IMM_S; end
      OPC_OPIMM: begin
        srcImm   = 1'b1;
        regWrite = 1'b1;
        case (funct3)
          F3_ADD:  aluOp = ALU_ADD;
          F3_SLT:  aluOp = ALU_SLT;
          F3_SLTU: aluOp = ALU_SLTU;
          F3_XOR:  aluOp = ALU_XOR;
          F3_OR:   aluOp = ALU_OR;
          F3_AND:  aluOp = ALU_AND;
          F3_SLL:  if (funct7 == F7_BASE) aluOp = ALU_SLL; else regWrite = 1'b0;
          F3_SR: begin
            if (funct7 == F7_BASE)     aluOp = ALU_SRL;
            else if (funct7 == F7_ALT) aluOp = ALU_SRA;
            else                       regWrite = 1'b0;
          end
          default: regWrite = 1'b0;
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          regWrite = 1'b1;
          case (funct3)
            F3_ADD:  aluOp = ALU_ADD;
            F3_SLL:  aluOp = ALU_SLL;
            F3_SLT:  aluOp = ALU_SLT;
            F3_SLTU: aluOp = ALU_SLTU;
            F3_XOR:  aluOp = ALU_XOR;
            F3_SR:   aluOp = ALU_SRL;
            F3_OR:   aluOp = ALU_OR;
            default: aluOp = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD)     begin regWrite = 1'b1; aluOp = ALU_SUB; end
          else if (funct3 == F3_SR) begin regWrite = 1'b1; aluOp = ALU_SRA; end
        end
`ifdef CPU_MUL_EN
        else if ((funct7 == F7_MULDIV) && (funct3 == F3_ADD)) begin
          regWrite = 1'b1;
          aluOp    = ALU_MUL;
        end
`endif
      end
      default: ;
    endcase
  end

  cpu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (rs1Addr),
    .rs2_addr_i (rs2Addr),
    .rs1_data_o (rs1Data),
    .rs2_data_o (rs2Data),
    .we_i       (commit && regWrite),
    .rd_addr_i  (rdAddr),
    .rd_data_i  (wbData)
  );

  assign imm  = imm_gen(im_data, immFmt);
  assign aluA = srcPc ? pc_q : rs1Data;
  assign aluB = srcImm ? imm : rs2Data;

  always_comb begin
    aluResult = '0;
    case (aluOp)
      ALU_ADD:   aluResult = aluA + aluB;
      ALU_SUB:   aluResult = aluA - aluB;
      ALU_SLL:   aluResult = aluA << aluB[4:0];
      ALU_SLT:   aluResult = {31'b0, $signed(aluA) < $signed(aluB)};
      ALU_SLTU:  aluResult = {31'b0, aluA < aluB};
      ALU_XOR:   aluResult = aluA ^ aluB;
      ALU_SRL:   aluResult = aluA >> aluB[4:0];
      ALU_SRA:   aluResult = $signed(aluA) >>> aluB[4:0];
      ALU_OR:    aluResult = aluA | aluB;
      ALU_AND:   aluResult = aluA & aluB;
      ALU_PASSB: aluResult = aluB;
      ALU_MUL:   aluResult = aluA * aluB;
      default:   aluResult = '0;
    endcase
  end

  always_comb begin
    brTaken = 1'b0;
    case (funct3)
      F3_BEQ:  brTaken = (rs1Data == rs2Data);
      F3_BNE:  brTaken = (rs1Data != rs2Data);
      F3_BLT:  brTaken = ($signed(rs1Data) < $signed(rs2Data));
      F3_BGE:  brTaken = ($signed(rs1Data) >= $signed(rs2Data));
      F3_BLTU: brTaken = (rs1Data < rs2Data);
      F3_BGEU: brTaken = (rs1Data >= rs2Data);
      default: brTaken = 1'b0;
    endcase
  end

  // A load/store can only retire once the data memory has answered.
  assign commit  = im_valid && (!(isLoad || isStore) || mem_valid);
  assign pcPlus4 = pc_q + 32'd4;
  assign wbData  = (isJal || isJalr) ? pcPlus4 : (isLoad ? mem_read_data : aluResult);

  always_comb begin
    pc_d = pc_q;
    if (commit) begin
      if (isJal || (isBranch && brTaken)) pc_d = pc_q + imm;
      else if (isJalr)                    pc_d = aluResult & ~32'd1;
      else                                pc_d = pcPlus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign im_addr        = pc_q;
  assign mem_addr       = aluResult;
  assign mem_write      = rst_n && im_valid && isStore;
  assign mem_write_data = rs2Data;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core with an instruction-level reference model.
// Build with CPU_MUL_EN defined to expect MUL results instead of a NOP.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_valid = 1'b0;
  logic [31:0] im_data = 32'h0;
  logic [31:0] im_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_read_data = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_write_data;

  int errors = 0;
  int checks = 0;

  cpu_core u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_valid       (im_valid),
    .im_data        (im_data),
    .im_addr        (im_addr),
    .mem_valid      (mem_valid),
    .mem_read_data  (mem_read_data),
    .mem_addr       (mem_addr),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] nextPc;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        isLs;
    logic        isSt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } effect_t;

  logic [31:0] mPc = 32'h0;
  logic [31:0] mRegs [32] = '{default: 32'h0};
  effect_t     eMod;
  effect_t     eCmp;

  // Architectural effect of one instruction against the model state.
  function automatic effect_t modelExec(input logic [31:0] ins, input logic [31:0] rdata);
    effect_t     e;
    logic [31:0] a, b, immI, immS, immB, immJ, immU;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    bit          tk, ok;
    f3   = ins[14:12];
    f7   = ins[31:25];
    a    = mRegs[ins[19:15]];
    b    = mRegs[ins[24:20]];
    sh   = ins[24:20];
    immI = {{20{ins[31]}}, ins[31:20]};
    immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    immU = {ins[31:12], 12'h0};
    e.nextPc = mPc + 32'd4;
    e.wr = 1'b0; e.rd = ins[11:7]; e.val = 32'h0;
    e.isLs = 1'b0; e.isSt = 1'b0; e.addr = 32'h0; e.wdata = b;
    tk = 0; ok = 1;
    case (ins[6:0])
      7'h37: begin e.wr = 1'b1; e.val = immU; end
      7'h17: begin e.wr = 1'b1; e.val = mPc + immU; end
      7'h6F: begin e.wr = 1'b1; e.val = mPc + 32'd4; e.nextPc = mPc + immJ; end
      7'h67: if (f3 == 3'd0) begin
        e.wr = 1'b1; e.val = mPc + 32'd4; e.nextPc = (a + immI) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: ok = 0;
        endcase
        if (ok && tk) e.nextPc = mPc + immB;
      end
      7'h03: if (f3 == 3'd2) begin
        e.isLs = 1'b1; e.addr = a + immI; e.wr = 1'b1; e.val = rdata;
      end
      7'h23: if (f3 == 3'd2) begin
        e.isLs = 1'b1; e.isSt = 1'b1; e.addr = a + immS;
      end
      7'h13: begin
        e.wr = 1'b1;
        case (f3)
          3'd0: e.val = a + immI;
          3'd2: e.val = ($signed(a) < $signed(immI)) ? 32'd1 : 32'd0;
          3'd3: e.val = (a < immI) ? 32'd1 : 32'd0;
          3'd4: e.val = a ^ immI;
          3'd6: e.val = a | immI;
          3'd7: e.val = a & immI;
          3'd1: if (f7 == 7'h00) e.val = a << sh; else e.wr = 1'b0;
          default: begin
            if (f7 == 7'h00)      e.val = a >> sh;
            else if (f7 == 7'h20) e.val = $signed(a) >>> sh;
            else                  e.wr = 1'b0;
          end
        endcase
      end
      7'h33: begin
        e.wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: e.val = a + b;
          {7'h20, 3'd0}: e.val = a - b;
          {7'h00, 3'd1}: e.val = a << b[4:0];
          {7'h00, 3'd2}: e.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: e.val = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: e.val = a ^ b;
          {7'h00, 3'd5}: e.val = a >> b[4:0];
          {7'h20, 3'd5}: e.val = $signed(a) >>> b[4:0];
          {7'h00, 3'd6}: e.val = a | b;
          {7'h00, 3'd7}: e.val = a & b;
`ifdef CPU_MUL_EN
          {7'h01, 3'd0}: e.val = a * b;
`endif
          default: e.wr = 1'b0;
        endcase
      end
      default: ;
    endcase
    if (e.rd == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc <= 32'h0;
      for (int i = 0; i < 32; i++) mRegs[i] <= 32'h0;
    end else if (im_valid) begin
      eMod = modelExec(im_data, mem_read_data);
      if (!eMod.isLs || mem_valid) begin
        if (eMod.wr) mRegs[eMod.rd] <= eMod.val;
        mPc <= eMod.nextPc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset im_addr", im_addr, 32'h0);
      checkOutput("reset mem_write", 32'(mem_write), 32'h0);
    end else begin
      eCmp = modelExec(im_data, mem_read_data);
      checkOutput("im_addr", im_addr, mPc);
      checkOutput("mem_write", 32'(mem_write), 32'(im_valid && eCmp.isSt));
      if (im_valid && eCmp.isLs) checkOutput("mem_addr", mem_addr, eCmp.addr);
      if (im_valid && eCmp.isSt) checkOutput("mem_write_data", mem_write_data, eCmp.wdata);
    end
  end

  function automatic logic [31:0] iType(input int op, input int f3, input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] rType(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] sType(input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] bType(input int f3, input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] jType(input int rd, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] uType(input int op, input int rd, input int imm20);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), 7'(op)};
  endfunction

  task automatic applyStimulus(input logic [31:0] ins, input logic iv, input logic mv, input logic [31:0] rdata);
    im_data       = ins;
    im_valid      = iv;
    mem_valid     = mv;
    mem_read_data = rdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exec(input logic [31:0] ins);
    applyStimulus(ins, 1'b1, 1'b1, 32'h0);
    step();
  endtask

  task automatic storeCheck(input string name, input int rs, input logic [31:0] expected);
    applyStimulus(sType(rs, 0, 0), 1'b1, 1'b1, 32'h0);
    checkOutput(name, mem_write_data, expected);
    step();
  endtask

  logic [31:0] mulExpect;

  initial begin
`ifdef CPU_MUL_EN
    mulExpect = 32'h0001_0000;
`else
    mulExpect = 32'h0000_000A;
`endif
    applyStimulus(sType(1, 0, 0), 1'b1, 1'b1, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("lit reset im_addr", im_addr, 32'h0);
    checkOutput("lit reset mem_write", 32'(mem_write), 32'h0);
    rst_n = 1'b1;

    exec(iType('h13, 0, 1, 0, 5));
    exec(iType('h13, 0, 2, 1, -7));
    checkOutput("lit pc after addi", im_addr, 32'd8);
    applyStimulus(sType(1, 0, 12), 1'b1, 1'b1, 32'h0);
    checkOutput("lit sw mem_write", 32'(mem_write), 32'h1);
    checkOutput("lit sw mem_addr", mem_addr, 32'd12);
    checkOutput("lit sw data x1", mem_write_data, 32'd5);
    step();
    applyStimulus(iType('h03, 2, 3, 0, 12), 1'b1, 1'b1, 32'd5);
    step();
    exec(bType(1, 0, 0, -8));
    checkOutput("lit bne not taken", im_addr, 32'd20);
    exec(bType(0, 0, 0, -4));
    checkOutput("lit beq -4", im_addr, 32'd16);
    exec(bType(0, 0, 0, -8));
    checkOutput("lit beq -8", im_addr, 32'd8);
    exec(jType(1, 16));
    checkOutput("lit jal target", im_addr, 32'd24);
    exec(iType('h67, 0, 0, 1, 1));
    checkOutput("lit jalr target", im_addr, 32'd12);
    storeCheck("lit lw x3", 3, 32'd5);
    storeCheck("lit x2", 2, 32'hFFFF_FFFE);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(sType(1, 0, 0), 1'b0, 1'b1, 32'h0);
      checkOutput("lit ifetch stall mem_write", 32'(mem_write), 32'h0);
      step();
    end
    checkOutput("lit pc after ifetch stall", im_addr, 32'd20);
    applyStimulus(sType(1, 0, 4), 1'b1, 1'b0, 32'h0);
    checkOutput("lit stalled sw mem_write", 32'(mem_write), 32'h1);
    step();
    checkOutput("lit pc during sw stall", im_addr, 32'd20);
    applyStimulus(sType(1, 0, 4), 1'b1, 1'b1, 32'h0);
    step();
    checkOutput("lit pc after sw commit", im_addr, 32'd24);

    exec(uType('h37, 5, 'h12345));
    exec(uType('h17, 6, 1));
    exec(rType('h00, 0, 4, 1, 2));
    exec(rType('h20, 0, 7, 4, 1));
    exec(rType('h20, 5, 8, 2, 4));
    exec(rType('h00, 5, 9, 2, 4));
    exec(rType('h00, 1, 10, 1, 4));
    exec(rType('h00, 2, 11, 2, 1));
    exec(rType('h00, 3, 12, 2, 1));
    exec(rType('h00, 4, 13, 5, 6));
    exec(rType('h00, 6, 14, 5, 6));
    exec(rType('h00, 7, 15, 5, 6));
    exec(iType('h13, 2, 16, 2, 0));
    exec(iType('h13, 3, 17, 1, -1));
    exec(iType('h13, 4, 18, 1, -1));
    exec(iType('h13, 6, 19, 0, 'h7FF));
    exec(iType('h13, 7, 20, 6, 'hFF));
    exec(iType('h13, 1, 21, 1, 4));
    exec(iType('h13, 5, 22, 2, 28));
    exec(iType('h13, 5, 23, 2, 'h401));
    exec(bType(4, 2, 1, 8));
    exec(bType(5, 2, 1, 8));
    exec(bType(6, 2, 1, 8));
    exec(bType(7, 2, 1, 8));
    storeCheck("lit add x4", 4, 32'h0000_000A);
    storeCheck("lit sra x8", 8, 32'hFFFF_FFFF);
    storeCheck("lit srl x9", 9, 32'h003F_FFFF);
    storeCheck("lit sll x10", 10, 32'h0000_3000);
    storeCheck("lit slt x11", 11, 32'h1);
    storeCheck("lit sltu x12", 12, 32'h0);
    storeCheck("lit xori x18", 18, 32'hFFFF_FFF3);
    storeCheck("lit slli x21", 21, 32'h0000_00C0);
    storeCheck("lit srli x22", 22, 32'h0000_000F);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(iType('h03, 2, 24, 0, 0), 1'b1, 1'b0, 32'h0);
      step();
    end
    applyStimulus(iType('h03, 2, 24, 0, 0), 1'b1, 1'b1, 32'hCAFE_F00D);
    step();
    storeCheck("lit stalled lw x24", 24, 32'hCAFE_F00D);

    exec(iType('h13, 0, 0, 0, 9));
    storeCheck("lit x0 stays zero", 0, 32'h0);
    applyStimulus(iType('h03, 0, 25, 0, 0), 1'b1, 1'b1, 32'h55);
    step();
    exec(32'h0000_000F);
    exec(32'h0000_0073);
    storeCheck("lit lb is nop", 25, 32'h0);

    exec(uType('h37, 1, 'h10));
    exec(uType('h37, 2, 'h10));
    exec(iType('h13, 0, 2, 2, 1));
    exec(rType('h01, 0, 4, 1, 2));
    exec(rType('h01, 5, 4, 1, 2));
    storeCheck("lit mul x4", 4, mulExpect);

    applyStimulus(sType(1, 0, 0), 1'b1, 1'b1, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("lit midreset im_addr", im_addr, 32'h0);
    checkOutput("lit midreset mem_write", 32'(mem_write), 32'h0);
    step();
    rst_n = 1'b1;
    storeCheck("lit x1 cleared by reset", 1, 32'h0);
    checkOutput("lit pc after post-reset sw", im_addr, 32'd4);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
